// File: rtl/doc_wave_mem_pkg.sv
// Shared types for the DOC5503 wave-memory responder.
package doc_wave_mem_pkg;

  // Deepest sound-RAM read pipeline the responder supports.
  localparam int unsigned RAM_LATENCY_MAX = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE_DOC,
    DONE_HOST,
    REARM
  } wave_mem_state_t;

  typedef enum logic {
    SRC_DOC,
    SRC_HOST
  } wave_mem_src_t;

endpackage

// File: rtl/doc_wave_mem_responder.sv
// Wave-memory responder: serves DOC byte reads and a queued host
// read/write port from one synchronous sound RAM, alternating on contention.
module doc_wave_mem_responder
  import doc_wave_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [ADDR_WIDTH-1:0] wave_address_i,
  input  logic                  wave_rd_i,
  output logic                  wave_data_ready_o,
  output logic [7:0]            wave_data_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [7:0]            host_data_i,
  output logic                  host_ack_o,
  output logic [7:0]            host_data_o,
  output logic                  host_ovf_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(RAM_LATENCY_MAX + 1);

  wave_mem_state_t       state_q, state_d;
  wave_mem_src_t         src_q;
  logic                  last_doc_q;
  logic                  pend_valid_q;
  logic                  pend_we_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [7:0]            pend_data_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic                  doc_elig, host_elig;
  logic                  grant_doc, grant_host;
  logic                  capture, consume;

  // Arbitration: a lone eligible source wins; on contention the source not
  // granted last time wins.
  always_comb begin
    doc_elig   = (state_q == IDLE) && wave_rd_i;
    host_elig  = (state_q == IDLE) && pend_valid_q;
    grant_doc  = doc_elig && !(host_elig && last_doc_q);
    grant_host = host_elig && !grant_doc;
    consume    = (state_q == DONE_HOST);
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state; with RAM_LATENCY=1 the read data is captured straight out of
  // ISSUE so WAIT is skipped and the response lands at grant+2.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_doc || grant_host) state_d = ISSUE;
      end
      ISSUE: begin
        // ram_we_o is only ever high in ISSUE, and only for a host write.
        if (ram_we_o) begin
          state_d = DONE_HOST;
        end else if (RAM_LATENCY <= 1) begin
          capture = 1'b1;
          state_d = (src_q == SRC_DOC) ? DONE_DOC : DONE_HOST;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q <= CNT_W'(1)) begin
          capture = 1'b1;
          state_d = (src_q == SRC_DOC) ? DONE_DOC : DONE_HOST;
        end
      end
      DONE_DOC:  state_d = REARM;
      DONE_HOST: state_d = IDLE;
      REARM: begin
        if (!wave_rd_i) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // RAM command, grant bookkeeping, latency counter and read-data capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      src_q       <= SRC_HOST;
      last_doc_q  <= 1'b0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_wdata_o <= '0;
      wait_cnt_q  <= '0;
      wave_data_o <= '0;
      host_data_o <= '0;
    end else begin
      if (grant_doc || grant_host) begin
        src_q      <= grant_doc ? SRC_DOC : SRC_HOST;
        last_doc_q <= grant_doc;
        ram_addr_o <= grant_doc ? wave_address_i : pend_addr_q;
        ram_we_o   <= grant_host && pend_we_q;
        if (grant_host && pend_we_q) ram_wdata_o <= pend_data_q;
      end else begin
        ram_we_o <= 1'b0;
      end
      if (state_q == ISSUE)     wait_cnt_q <= CNT_W'(RAM_LATENCY - 1);
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q - CNT_W'(1);
      if (capture) begin
        if (src_q == SRC_DOC) wave_data_o <= ram_rdata_i;
        else                  host_data_o <= ram_rdata_i;
      end
    end
  end

  // One-entry host request slot; a request arriving while it is occupied
  // (and not being freed this cycle) is dropped and flagged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      host_ovf_o   <= 1'b0;
    end else if (host_req_i) begin
      if (pend_valid_q && !consume) begin
        host_ovf_o <= 1'b1;
      end else begin
        pend_valid_q <= 1'b1;
        pend_we_q    <= host_we_i;
        pend_addr_q  <= host_addr_i;
        pend_data_q  <= host_data_i;
      end
    end else if (consume) begin
      pend_valid_q <= 1'b0;
    end
  end

  assign wave_data_ready_o = (state_q == DONE_DOC);
  assign host_ack_o        = (state_q == DONE_HOST);
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_doc_wave_mem_responder.sv
// Directed bench for doc_wave_mem_responder: one instance at RAM_LATENCY=1
// with a writable RAM model, one at RAM_LATENCY=2 with a read-only pipeline.
module tb_doc_wave_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // DUT A (latency 1)
  logic        rst_a_n, wrd_a, rdy_a, hreq_a, hwe_a, hack_a, hovf_a, rwe_a, busy_a;
  logic [15:0] wa_a, haddr_a, raddr_a;
  logic [7:0]  wdata_a, hdin_a, hdout_a, rwdata_a, rrdata_a;
  // DUT B (latency 2)
  logic        rst_b_n, wrd_b, rdy_b, hreq_b, hwe_b, hack_b, hovf_b, rwe_b, busy_b;
  logic [15:0] wa_b, haddr_b, raddr_b;
  logic [7:0]  wdata_b, hdin_b, hdout_b, rwdata_b, rrdata_b;

  doc_wave_mem_responder #(.ADDR_WIDTH(16), .RAM_LATENCY(1)) dut_a (
    .clk_i(clk), .reset_n_i(rst_a_n),
    .wave_address_i(wa_a), .wave_rd_i(wrd_a),
    .wave_data_ready_o(rdy_a), .wave_data_o(wdata_a),
    .host_req_i(hreq_a), .host_we_i(hwe_a), .host_addr_i(haddr_a), .host_data_i(hdin_a),
    .host_ack_o(hack_a), .host_data_o(hdout_a), .host_ovf_o(hovf_a),
    .ram_addr_o(raddr_a), .ram_we_o(rwe_a), .ram_wdata_o(rwdata_a), .ram_rdata_i(rrdata_a),
    .busy_o(busy_a)
  );

  doc_wave_mem_responder #(.ADDR_WIDTH(16), .RAM_LATENCY(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_b_n),
    .wave_address_i(wa_b), .wave_rd_i(wrd_b),
    .wave_data_ready_o(rdy_b), .wave_data_o(wdata_b),
    .host_req_i(hreq_b), .host_we_i(hwe_b), .host_addr_i(haddr_b), .host_data_i(hdin_b),
    .host_ack_o(hack_b), .host_data_o(hdout_b), .host_ovf_o(hovf_b),
    .ram_addr_o(raddr_b), .ram_we_o(rwe_b), .ram_wdata_o(rwdata_b), .ram_rdata_i(rrdata_b),
    .busy_o(busy_b)
  );

  // Preset sound-RAM contents with hand-picked values at the test addresses.
  function automatic logic [7:0] pat(input logic [15:0] a);
    case (a)
      16'h1234: pat = 8'h5A;
      16'h0100: pat = 8'hA1;
      16'h0200: pat = 8'hB2;
      16'h0300: pat = 8'hC4;
      16'h0400: pat = 8'hD8;
      16'h0042: pat = 8'h99;
      16'h0043: pat = 8'h77;
      default:  pat = a[7:0] ^ a[15:8];
    endcase
  endfunction

  // RAM A: data for the registered address is presented in the same cycle,
  // so the DUT sees it at grant+1. RAM B adds one register stage (grant+2).
  logic       ram_init;
  logic [7:0] mem_a [0:65535];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) mem_a[i] <= pat(16'(i));
    end else if (rwe_a) begin
      mem_a[raddr_a] <= rwdata_a;
    end
  end
  assign rrdata_a = mem_a[raddr_a];
  always @(posedge clk) rrdata_b <= pat(raddr_b);

  // Pulse monitor: grant order on A (0 = DOC, 1 = host) and pulse counts.
  logic       mon_clr;
  logic [7:0] ord_bits;
  int         ord_len, n_rdy_a, n_ack_a, n_rdy_b;
  always @(negedge clk) begin
    if (mon_clr) begin
      ord_bits <= '0; ord_len <= 0; n_rdy_a <= 0; n_ack_a <= 0; n_rdy_b <= 0;
    end else begin
      if (rdy_a) begin
        ord_bits <= {ord_bits[6:0], 1'b0}; ord_len <= ord_len + 1; n_rdy_a <= n_rdy_a + 1;
      end else if (hack_a) begin
        ord_bits <= {ord_bits[6:0], 1'b1}; ord_len <= ord_len + 1; n_ack_a <= n_ack_a + 1;
      end
      if (rdy_b) n_rdy_b <= n_rdy_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; @(negedge clk); #1; mon_clr = 1'b0; @(posedge clk); #1;
  endtask

  int base;

  initial begin
    {wrd_a, hreq_a, hwe_a, wrd_b, hreq_b, hwe_b} = '0;
    {wa_a, haddr_a, wa_b, haddr_b} = '0;
    {hdin_a, hdin_b} = '0;
    rst_a_n = 1'b0; rst_b_n = 1'b0; mon_clr = 1'b1; ram_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_flags", 32'({rdy_a, hack_a, hovf_a, rwe_a, busy_a}), 32'h0);
    chk("rst_a_data",  32'({wdata_a, hdout_a, rwdata_a}), 32'h0);
    chk("rst_a_addr",  32'(raddr_a), 32'h0);
    rst_a_n = 1'b1; rst_b_n = 1'b1; mon_clr = 1'b0; ram_init = 1'b0;
    tick();

    // Single DOC read, held request served once
    wa_a = 16'h1234; wrd_a = 1'b1;
    tick();
    chk("t1_addr", 32'(raddr_a), 32'h1234);
    chk("t1_busy", 32'(busy_a), 32'h1);
    chk("t1_rdy_early", 32'(rdy_a), 32'h0);
    tick();
    chk("t1_rdy", 32'(rdy_a), 32'h1);
    chk("t1_data", 32'(wdata_a), 32'h5A);
    repeat (5) tick();
    chk("t1_single_pulse", 32'(n_rdy_a), 32'd1);
    chk("t1_rearm_busy", 32'(busy_a), 32'h1);
    chk("t1_data_hold", 32'(wdata_a), 32'h5A);
    wrd_a = 1'b0;
    tick();
    chk("t1_idle", 32'(busy_a), 32'h0);

    // Host write then read back
    hreq_a = 1'b1; hwe_a = 1'b1; haddr_a = 16'h00FF; hdin_a = 8'hC3;
    tick();
    hreq_a = 1'b0; hwe_a = 1'b0; hdin_a = 8'h00;
    chk("t2_we_grant", 32'(rwe_a), 32'h0);
    tick();
    chk("t2_we", 32'(rwe_a), 32'h1);
    chk("t2_waddr", 32'(raddr_a), 32'h00FF);
    chk("t2_wdata", 32'(rwdata_a), 32'hC3);
    chk("t2_ack_early", 32'(hack_a), 32'h0);
    tick();
    chk("t2_we_off", 32'(rwe_a), 32'h0);
    chk("t2_wack", 32'(hack_a), 32'h1);
    tick();
    chk("t2_ack_off", 32'(hack_a), 32'h0);
    hreq_a = 1'b1; haddr_a = 16'h00FF;
    tick();
    hreq_a = 1'b0;
    tick();
    chk("t2_rd_no_we", 32'(rwe_a), 32'h0);
    tick();
    chk("t2_rack", 32'(hack_a), 32'h1);
    chk("t2_rdata", 32'(hdout_a), 32'hC3);
    tick();
    chk("t2_ack_count", 32'(n_ack_a), 32'd2);

    // Contention from reset: same-cycle pair, repeated
    rst_a_n = 1'b0;
    clear_mon();
    rst_a_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      wa_a = (p == 0) ? 16'h0100 : 16'h0300; wrd_a = 1'b1;
      haddr_a = (p == 0) ? 16'h0200 : 16'h0400; hreq_a = 1'b1;
      tick();
      hreq_a = 1'b0;
      tick();
      chk("t3_rdy", 32'(rdy_a), 32'h1);
      chk("t3_doc_data", 32'(wdata_a), (p == 0) ? 32'hA1 : 32'hC4);
      wrd_a = 1'b0;
      repeat (4) tick();
      chk("t3_ack", 32'(hack_a), 32'h1);
      chk("t3_host_data", 32'(hdout_a), (p == 0) ? 32'hB2 : 32'hD8);
      tick();
    end
    chk("t3_order_len", 32'(ord_len), 32'd4);
    chk("t3_order", 32'(ord_bits[3:0]), 32'b0101);

    // Both eligible in IDLE: host after a DOC grant, DOC after a host grant
    wa_a = 16'h0100; wrd_a = 1'b1;
    tick();
    hreq_a = 1'b1; haddr_a = 16'h0200;
    tick();
    hreq_a = 1'b0; wrd_a = 1'b0;
    tick();
    tick();
    wa_a = 16'h0300; wrd_a = 1'b1;
    tick();
    chk("tf_host_first", 32'(raddr_a), 32'h0200);
    tick();
    chk("tf_ack", 32'(hack_a), 32'h1);
    chk("tf_host_data", 32'(hdout_a), 32'hB2);
    hreq_a = 1'b1; haddr_a = 16'h0400;
    tick();
    hreq_a = 1'b0;
    tick();
    chk("tf_doc_next", 32'(raddr_a), 32'h0300);
    tick();
    chk("tf_rdy", 32'(rdy_a), 32'h1);
    chk("tf_doc_data", 32'(wdata_a), 32'hC4);
    wrd_a = 1'b0;
    repeat (3) tick();
    chk("tf_slot_reuse", 32'(raddr_a), 32'h0400);
    tick();
    chk("tf_ack2", 32'(hack_a), 32'h1);
    chk("tf_host_data2", 32'(hdout_a), 32'hD8);
    chk("tf_no_ovf", 32'(hovf_a), 32'h0);
    tick();
    chk("tf_order_len", 32'(ord_len), 32'd8);
    chk("tf_order", 32'(ord_bits), 32'h55);

    // Overflow: second host request while the first is still pending
    base = n_ack_a;
    wa_a = 16'h1234; wrd_a = 1'b1;
    tick();
    hreq_a = 1'b1; hwe_a = 1'b0; haddr_a = 16'h00FF;
    tick();
    hreq_a = 1'b1; hwe_a = 1'b1; haddr_a = 16'h00FF; hdin_a = 8'h11; wrd_a = 1'b0;
    tick();
    hreq_a = 1'b0; hwe_a = 1'b0; hdin_a = 8'h00;
    chk("t4_ovf_set", 32'(hovf_a), 32'h1);
    repeat (3) tick();
    chk("t4_ack", 32'(hack_a), 32'h1);
    chk("t4_data", 32'(hdout_a), 32'hC3);
    repeat (4) tick();
    chk("t4_one_ack", 32'(n_ack_a - base), 32'd1);
    chk("t4_ovf_sticky", 32'(hovf_a), 32'h1);
    chk("t4_ram_kept", 32'(mem_a[16'h00FF]), 32'hC3);

    // Reset during a host write cancels it
    hreq_a = 1'b1; hwe_a = 1'b1; haddr_a = 16'h0500; hdin_a = 8'h66;
    tick();
    hreq_a = 1'b0; hwe_a = 1'b0; hdin_a = 8'h00;
    tick();
    chk("t5_we_inflight", 32'(rwe_a), 32'h1);
    #2 rst_a_n = 1'b0;
    #1;
    chk("t5_rst_flags", 32'({rdy_a, hack_a, hovf_a, rwe_a, busy_a}), 32'h0);
    chk("t5_rst_data", 32'({wdata_a, hdout_a, rwdata_a}), 32'h0);
    tick();
    chk("t5_no_write", 32'(mem_a[16'h0500]), 32'h05);
    rst_a_n = 1'b1;
    tick();

    // RAM_LATENCY=2: ready at grant+3
    wa_b = 16'h0042; wrd_b = 1'b1;
    tick();
    chk("t6_addr", 32'(raddr_b), 32'h0042);
    tick();
    chk("t6_rdy_early", 32'(rdy_b), 32'h0);
    chk("t6_busy", 32'(busy_b), 32'h1);
    tick();
    chk("t6_rdy", 32'(rdy_b), 32'h1);
    chk("t6_data", 32'(wdata_b), 32'h99);
    wrd_b = 1'b0;
    repeat (2) tick();
    // Reset while in WAIT
    wa_b = 16'h0043; wrd_b = 1'b1;
    repeat (2) tick();
    #2 rst_b_n = 1'b0;
    #1;
    chk("t6_rst_flags", 32'({rdy_b, hack_b, hovf_b, rwe_b, busy_b}), 32'h0);
    chk("t6_rst_data", 32'({wdata_b, hdout_b, rwdata_b}), 32'h0);
    chk("t6_rst_addr", 32'(raddr_b), 32'h0);
    wrd_b = 1'b0;
    repeat (3) tick();
    chk("t6_no_pulse", 32'(n_rdy_b), 32'd1);
    rst_b_n = 1'b1;
    tick();
    wa_b = 16'h0043; wrd_b = 1'b1;
    repeat (3) tick();
    chk("t6_after_rst_rdy", 32'(rdy_b), 32'h1);
    chk("t6_after_rst_data", 32'(wdata_b), 32'h77);
    wrd_b = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
